ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port arbiter and sequencer for the main RAM. It shares a single RAM access path between two requesters: port 0 is the CPU memory stage and port 1 is the DMA/peripheral master. It latches one request at a time, range-checks the address against the RAM window, and sequences the RAM read or write strobe. It then waits a fixed read latency and returns a one-cycle acknowledge with read data.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 16, data word width in bits
RAM_BASE, 16'h4000, first valid RAM address
RAM_DEPTH, 16'h4000, number of words in the RAM window
LATENCY, 1, RAM read latency in cycles (legal range 1..7)

Ports:
reset  in  1  asynchronous, active-high reset
read_clk  in  1  block clock; all state updates on its rising edge
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse
req1 / we1 / addr1 / wdata1  in  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0
ack1  out  1  port 1 completion pulse
rdata  out  DATA_W  read data; valid only while ack0 or ack1 is high
err  out  1  address out of range; valid only while ack0 or ack1 is high
busy  out  1  high in any state other than IDLE
ram_addr  out  ADDR_W  word offset into RAM (address minus RAM_BASE)
ram_wdata  out  DATA_W  RAM write data
ram_re  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state goes to IDLE; no ack is issued for an aborted transaction.
  - ack0, ack1, err, ram_re, ram_we, busy reset to 0; rdata, ram_addr, ram_wdata reset to 0.
  - round-robin pointer last=1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - requests are sampled only in this state.
  - If exactly one req is high, that port wins.
  - If both are high, the port other than `last` wins, and `last` is set to the winner.
  - The winner's we, addr and wdata are latched into internal registers, and the state goes to ISSUE.
  - Request lines are ignored in every other state.
- ISSUE (1 cycle), in-range address (RAM_BASE <= addr < RAM_BASE+RAM_DEPTH, compared at ADDR_W width with no wrap):
  - ram_addr = addr - RAM_BASE.
  - Write: ram_we=1 and ram_wdata is driven, then go to RESP.
  - Read: ram_re=1, load the latency counter with LATENCY, then go to WAIT.
- ISSUE, out-of-range address: no strobe is asserted; set the error flag and go to RESP.
- WAIT:
  - the counter decrements each cycle.
  - On the edge where it reaches 0, capture ram_rdata into rdata and go to RESP.
- RESP (1 cycle):
  - ack of the granted port is high; err is as flagged.
  - rdata holds the captured value for a read, 0 for an error, and is unchanged for a write.
  - Then go to IDLE.
- Latency, with req sampled in IDLE at edge t:
  - write: ram_we high in cycle t+1, ack high in cycle t+2.
  - read: ram_re high in cycle t+1, ack high in cycle t+2+LATENCY.
- Handshake rules:
  - a requester drops req in the cycle after ack, or the next IDLE sample starts a new transaction (back-to-back access is legal).
  - minimum spacing between grants is 3 cycles for a write.
  - A req withdrawn after latching still completes and is still acked.
  - A req withdrawn before the IDLE sample is never served.
- ram_re and ram_we are never high together.
- ack0 and ack1 are never high together.

Optional Feature:
ARB_FIXED_PRIO_EN:
- defined: port 0 always wins a tie in IDLE, and the `last` pointer is unused; port 1 may starve.
- undefined: round-robin tie-break as described in Behaviour.
- All timing is identical in both builds.

Test Plan:
1. Reset during WAIT of a port 1 read (LATENCY=3) -> all outputs 0 immediately, no ack1; a subsequent port 0 write is acked 2 cycles after its sample.
2. Port 0 writes 16'hBEEF to 16'h4005, then reads 16'h4005 -> ram_we with ram_addr=16'h0005 in cycle t+1; read ack0 in cycle t+2+LATENCY with rdata=16'hBEEF, err=0.
3. Both ports request reads continuously from reset -> grants alternate 0,1,0,1 (with ARB_FIXED_PRIO_EN: 0,0,0,...) and acks never overlap.
4. Port 1 reads 16'h3FFF and 16'h8000 -> no ram_re, ack1 with err=1 and rdata=0; 16'h7FFF reads normally with err=0.
5. Port 0 write with req0 dropped in the ISSUE cycle -> ram_we is still issued and ack0 still pulses once; no second transaction follows.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter and sequencer sharing one main-RAM access path.
// Optional build macro ARB_FIXED_PRIO_EN: port 0 always wins a tie.
module ram_arbiter #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 16'h4000,
    parameter logic [ADDR_W-1:0] RAM_DEPTH = 16'h4000,
    parameter int                LATENCY   = 1
) (
    input  logic              reset,
    input  logic              read_clk,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Window end computed one bit wider so RAM_BASE+RAM_DEPTH cannot wrap
    localparam logic [ADDR_W:0] RAM_LO  = {1'b0, RAM_BASE};
    localparam logic [ADDR_W:0] RAM_END = {1'b0, RAM_BASE} + {1'b0, RAM_DEPTH};
    localparam logic [2:0]      LAT     = 3'(LATENCY);

    state_t            state;
    state_t            state_nxt;
    logic              port_q;
    logic              we_q;
    logic              inr_q;
    logic              err_q;
    logic [2:0]        cnt_q;
    logic              pick1;
    logic              any_req;
    logic [ADDR_W-1:0] win_addr;
    logic              win_inr;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    logic last_q;
    assign pick1 = req1 & (~req0 | ~last_q);
`endif

    assign any_req  = req0 | req1;
    assign win_addr = pick1 ? addr1 : addr0;
    assign win_inr  = ({1'b0, win_addr} >= RAM_LO) &&
                      ({1'b0, win_addr} <  RAM_END);

    // State register, cleared asynchronously so aborted accesses never ack
    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and strobe/ack decode
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err       = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (inr_q && !we_q) begin
                    ram_re    = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    ram_we    = inr_q;
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) state_nxt = RESP;
            end
            RESP: begin
                ack0      = ~port_q;
                ack1      = port_q;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, latency counter and read-data capture
    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            inr_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 3'd0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        port_q    <= pick1;
                        we_q      <= pick1 ? we1 : we0;
                        inr_q     <= win_inr;
                        err_q     <= 1'b0;
                        ram_addr  <= win_addr - RAM_BASE;
                        ram_wdata <= pick1 ? wdata1 : wdata0;
                    end
                end
                ISSUE: begin
                    if (!inr_q) begin
                        err_q <= 1'b1;
                        rdata <= '0;
                    end else if (!we_q) begin
                        cnt_q <= LAT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) rdata <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer moves only when a tie is resolved
    always_ff @(posedge read_clk or posedge reset) begin
        if (reset)                          last_q <= 1'b1;
        else if (state == IDLE && req0 && req1) last_q <= pick1;
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter (LATENCY=3) with a small RAM model.
// Grant-order expectation follows ARB_FIXED_PRIO_EN when defined.
module tb_ram_arbiter;

    logic        reset;
    logic        read_clk;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, err, busy, ram_re, ram_we;
    logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata;

    int vectors;
    int miscompares;
    int overlaps;

    logic [15:0] mem [0:255];
    logic [15:0] rd_q;

    ram_arbiter #(
        .ADDR_W(16), .DATA_W(16),
        .RAM_BASE(16'h4000), .RAM_DEPTH(16'h4000),
        .LATENCY(3)
    ) dut (
        .reset(reset), .read_clk(read_clk),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    // RAM model: write on strobe, read data registered on the read strobe
    always @(posedge read_clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_re) rd_q <= mem[ram_addr[7:0]];
    end
    assign ram_rdata = rd_q;

    // Track forbidden overlaps throughout the run
    always @(negedge read_clk) begin
        if (ram_re && ram_we) overlaps++;
        if (ack0 && ack1)     overlaps++;
    end

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0]  exp_seq;
    logic        got;

    initial begin
        vectors = 0; miscompares = 0; overlaps = 0;
        rd_q = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
`ifdef ARB_FIXED_PRIO_EN
        exp_seq = 4'b0000;
`else
        exp_seq = 4'b1010;
`endif
        tick(); tick();
        chk("rst_ctl", {26'd0, busy, ack0, ack1, err, ram_re, ram_we}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        reset = 1'b0;
        tick();

        // 1: reset during WAIT of a port 1 read
        req1 = 1; we1 = 0; addr1 = 16'h4010;
        tick();
        chk("t1_issue_re", ram_re, 1);
        chk("t1_issue_addr", ram_addr, 16'h0010);
        req1 = 0;
        tick(); tick();
        chk("t1_wait_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_ctl", {26'd0, busy, ack0, ack1, err, ram_re, ram_we}, 0);
        chk("t1_async_data", {rdata, ram_addr}, 0);
        tick();
        chk("t1_no_ack1", ack1, 0);
        reset = 1'b0;
        req0 = 1; we0 = 1; addr0 = 16'h4005; wdata0 = 16'hBEEF;
        tick();
        chk("t2_we", {ram_we, ram_re}, 2'b10);
        chk("t2_we_addr", ram_addr, 16'h0005);
        chk("t2_we_data", ram_wdata, 16'hBEEF);
        chk("t2_no_ack_early", ack0, 0);
        req0 = 0;
        tick();
        chk("t2_w_ack", {ack0, ack1, err}, 3'b100);
        tick();
        chk("t2_w_done", {ack0, busy}, 0);

        // 2: read back the word just written
        req0 = 1; we0 = 0; addr0 = 16'h4005;
        tick();
        chk("t2_re", {ram_re, ram_we}, 2'b10);
        chk("t2_re_addr", ram_addr, 16'h0005);
        req0 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait_noack", ack0, 0);
        end
        tick();
        chk("t2_r_ack", {ack0, ack1, err}, 3'b100);
        chk("t2_r_data", rdata, 16'hBEEF);
        tick();

        // 4: port 1 range checks
        req1 = 1; we1 = 0; addr1 = 16'h3FFF;
        tick();
        chk("t4_lo_nostrobe", {ram_re, ram_we}, 0);
        req1 = 0;
        tick();
        chk("t4_lo_ack", {ack0, ack1, err}, 3'b011);
        chk("t4_lo_rdata", rdata, 0);
        tick();
        req1 = 1; addr1 = 16'h8000;
        tick();
        chk("t4_hi_nostrobe", {ram_re, ram_we}, 0);
        req1 = 0;
        tick();
        chk("t4_hi_ack", {ack0, ack1, err}, 3'b011);
        chk("t4_hi_rdata", rdata, 0);
        tick();
        req1 = 1; addr1 = 16'h7FFF;
        tick();
        chk("t4_top_re", ram_re, 1);
        chk("t4_top_addr", ram_addr, 16'h3FFF);
        req1 = 0;
        tick(); tick(); tick(); tick();
        chk("t4_top_ack", {ack0, ack1, err}, 3'b010);
        chk("t4_top_rdata", rdata, 16'h10FF);
        tick();

        // 5: write with req dropped in ISSUE
        req0 = 1; we0 = 1; addr0 = 16'h4100; wdata0 = 16'h1234;
        tick();
        req0 = 0;
        chk("t5_we", ram_we, 1);
        chk("t5_addr", ram_addr, 16'h0100);
        tick();
        chk("t5_ack", ack0, 1);
        tick();
        chk("t5_ack_once", {ack0, busy}, 0);
        tick();
        chk("t5_no_second", {busy, ram_we, ack0}, 0);

        // 3: both ports request reads continuously from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1; we0 = 0; addr0 = 16'h4001;
        req1 = 1; we1 = 0; addr1 = 16'h4002;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                if (ack0 || ack1) got = 1'b1;
            end
            chk("t3_ack_seen", got, 1);
            chk("t3_grant", ack1, exp_seq[g]);
            chk("t3_rdata", rdata, exp_seq[g] ? 16'h1002 : 16'h1001);
        end
        req0 = 0; req1 = 0;
        tick(); tick();
        chk("t3_idle", busy, 0);

        chk("no_overlap", overlaps, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
